// File: rtl/i2c_target_regs_if.sv
// I2C pad-level bundle shared by the target and whatever models the bus.
// scl_i/sda_i are pad levels; scl_o/sda_o are open-drain drives (0 = pull low).
interface i2c_target_regs_if;
  logic scl_i;
  logic sda_i;
  logic scl_o;
  logic sda_o;

  modport master (output scl_i, output sda_i, input scl_o, input sda_o);
  modport slave  (input scl_i, input sda_i, output scl_o, output sda_o);
endinterface

// File: rtl/i2c_target_regs.sv
// I2C target with a byte-wide register file and an auto-incrementing pointer.
// Write: ADDR+W, pointer byte, data bytes. Read: ADDR+R streams from the pointer.
module i2c_target_regs #(
  parameter logic [6:0] I2C_ADDR  = 7'h2A,
  parameter int         NUM_REGS  = 4,
  parameter int         PTR_W     = 8,
  parameter logic [7:0] REG_RESET = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  i2c_target_regs_if.slave      bus,
  output logic [NUM_REGS*8-1:0] reg_q,
  output logic                  wr_strobe,
  output logic [7:0]            wr_idx,
  output logic                  busy
);

  localparam int          IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [31:0] NREGS = 32'(NUM_REGS);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ADDR   = 3'd1;
  localparam logic [2:0] ACK    = 3'd2;
  localparam logic [2:0] PTR    = 3'd3;
  localparam logic [2:0] WDATA  = 3'd4;
  localparam logic [2:0] RDATA  = 3'd5;
  localparam logic [2:0] IGNORE = 3'd6;

  logic             scl_p0, scl_p1, scl_p2;
  logic             sda_p0, sda_p1, sda_p2;
  logic [2:0]       state, ret_state;
  logic             ack_on;
  logic [3:0]       cnt;
  logic [7:0]       sh, tx, wr_data;
  logic [PTR_W-1:0] ptr;
  logic             sda_drv;
  logic [7:0]       regs [NUM_REGS];

  logic scl_rise, scl_fall, start_cond, stop_cond, ptr_ok;
  logic [7:0] rx_byte, rd_cur, rd_next;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (32'(p) == NREGS - 32'd1) return '0;
    if (32'(p) < NREGS) return p + 1'b1;
    return p;
  endfunction

  function automatic logic [7:0] rd_byte(input logic [PTR_W-1:0] p);
    if (32'(p) < NREGS) return regs[p[IDX_W-1:0]];
    return 8'hFF;
  endfunction

  // Stage p0/p1: two-flop synchroniser; p2: previous level for edge decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_p0 <= 1'b1; scl_p1 <= 1'b1; scl_p2 <= 1'b1;
      sda_p0 <= 1'b1; sda_p1 <= 1'b1; sda_p2 <= 1'b1;
    end else begin
      scl_p0 <= bus.scl_i; scl_p1 <= scl_p0; scl_p2 <= scl_p1;
      sda_p0 <= bus.sda_i; sda_p1 <= sda_p0; sda_p2 <= sda_p1;
    end
  end

  assign scl_rise   = scl_p1 & ~scl_p2;
  assign scl_fall   = ~scl_p1 & scl_p2;
  assign start_cond = ~sda_p1 & sda_p2 & scl_p1 & scl_p2;
  assign stop_cond  = sda_p1 & ~sda_p2 & scl_p1 & scl_p2;
  assign rx_byte    = {sh[6:0], sda_p1};
  assign ptr_ok     = 32'(ptr) < NREGS;
  assign rd_cur     = rd_byte(ptr);
  assign rd_next    = rd_byte(ptr_inc(ptr));

  // Protocol FSM: bus conditions first, then per-state SCL edge handling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE; ret_state <= IDLE; ack_on <= 1'b0; cnt <= '0;
      sh <= '0; tx <= '1; ptr <= '0; sda_drv <= 1'b1; busy <= 1'b0;
      wr_strobe <= 1'b0; wr_idx <= '0; wr_data <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (start_cond) begin
        state <= ADDR; cnt <= '0; sda_drv <= 1'b1; busy <= 1'b1; ack_on <= 1'b0;
      end else if (stop_cond) begin
        state <= IDLE; sda_drv <= 1'b1; busy <= 1'b0; ack_on <= 1'b0;
      end else begin
        case (state)
          ADDR, PTR, WDATA: if (scl_rise) begin
            sh  <= rx_byte;
            cnt <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt   <= '0;
              state <= ACK;
              if (state == ADDR) begin
                if (rx_byte[7:1] == I2C_ADDR) ret_state <= rx_byte[0] ? RDATA : PTR;
                else state <= IGNORE;
              end else if (state == PTR) begin
                ptr <= rx_byte;
                ret_state <= WDATA;
              end else begin
                if (ptr_ok) begin
                  wr_strobe <= 1'b1;
                  wr_idx    <= ptr;
                  wr_data   <= rx_byte;
                end
                ptr <= ptr_inc(ptr);
                ret_state <= WDATA;
              end
            end
          end
          ACK: if (scl_fall) begin
            if (!ack_on) begin
              sda_drv <= 1'b0;
              ack_on  <= 1'b1;
            end else begin
              ack_on <= 1'b0;
              cnt    <= '0;
              state  <= ret_state;
              if (ret_state == RDATA) begin
                sda_drv <= rd_cur[7];
                tx      <= {rd_cur[6:0], 1'b1};
              end else begin
                sda_drv <= 1'b1;
              end
            end
          end
          RDATA: begin
            // Shifting in ones releases SDA automatically after bit 0
            if (scl_fall) begin
              sda_drv <= tx[7];
              tx      <= {tx[6:0], 1'b1};
            end
            if (scl_rise) begin
              cnt <= cnt + 4'd1;
              if (cnt == 4'd8) begin
                if (!sda_p1) begin
                  ptr <= ptr_inc(ptr);
                  tx  <= rd_next;
                  cnt <= '0;
                end else begin
                  state <= IGNORE;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Register file commits one clk after the strobe is raised
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= REG_RESET;
    end else if (wr_strobe) begin
      regs[wr_idx[IDX_W-1:0]] <= wr_data;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign reg_q[8*k +: 8] = regs[k];
  end

  assign bus.sda_o = sda_drv;
  assign bus.scl_o = 1'b1;

endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
Parametrised I2C target (slave) with an internal byte-wide register file, auto-incrementing register pointer, repeated-START support and open-drain style outputs. It replaces the fixed single-function i2c block in the tt_um top level. The top-level pad mapping is unchanged: sda_i/scl_i come from uio_in, and sda_o/scl_o drive the uio_oe bits. Register contents are exported as a flat bus for on-chip consumers.

Parameters:
I2C_ADDR, 7'h2A, 7-bit target address matched after START.
NUM_REGS, 4, number of 8-bit registers; must be at least 2.
PTR_W, 8, pointer byte width; fixed at 8, ignored bits above clog2(NUM_REGS) select "out of range".
REG_RESET, 8'h00, reset value of every register.

Ports:
clk  input  1  system clock; must run at least 8x the SCL frequency.
rst_n  input  1  asynchronous active-low reset.
scl_i  input  1  SCL pad level, asynchronous.
sda_i  input  1  SDA pad level, asynchronous.
scl_o  output  1  SCL drive: 0 = pull low, 1 = release. Tied to 1 (no clock stretching).
sda_o  output  1  SDA drive: 0 = pull low, 1 = release.
reg_q  output  NUM_REGS*8  register file contents; reg k is bits [8k+7:8k].
wr_strobe  output  1  one-clk pulse when a data byte is written to an in-range register.
wr_idx  output  8  index of the register written; valid while wr_strobe = 1.
busy  output  1  high from START until STOP.

Behaviour:
- Reset (async, rst_n = 0):
  - sda_o = 1, scl_o = 1, busy = 0, wr_strobe = 0, wr_idx = 0.
  - pointer = 0, all registers = REG_RESET, state = IDLE.
  - Synchronisers preset to 1.
  - Reset mid-transfer aborts the transaction immediately and releases SDA.
- Input conditioning:
  - 2-FF synchroniser on each of scl_i and sda_i, plus a third "previous" stage.
  - SCL rise/fall and SDA rise/fall are single-clk pulses decoded from the synchronised levels.
- Bus conditions:
  - START: SDA falls while SCL = 1.
  - STOP: SDA rises while SCL = 1.
  - START in any state (including repeated START) goes to ADDR, clears the bit counter, releases SDA and sets busy = 1.
  - STOP in any state goes to IDLE, releases SDA and sets busy = 0.
  - START/STOP take priority over the SCL edge logic on the same clk.
- Bit timing:
  - Receive: sample SDA on SCL rise, MSB first.
  - Drive: change sda_o only on SCL fall.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. After the 8th rise, if addr[7:1] == I2C_ADDR go to ACK_ADDR, else go to IGNORE (SDA stays released until STOP/START).
  - ACK_ADDR: on the next SCL fall drive sda_o = 0; on the following fall release it.
    - If R/W = 0: go to PTR.
    - If R/W = 1: go to RDATA, load the byte at pointer and drive its MSB on that same fall.
  - PTR: shift 8 bits into pointer, then ACK (same timing as ACK_ADDR), then go to WDATA.
  - WDATA: shift 8 bits, then ACK. On the 8th rise:
    - If pointer < NUM_REGS: write register[pointer] and pulse wr_strobe with wr_idx = pointer.
    - Otherwise discard the byte but still ACK.
    - Increment the pointer. Stay in WDATA for further bytes.
  - RDATA: shift the byte out on SCL falls. After the 8th bit release SDA; on the 9th SCL rise sample the master's ACK.
    - ACK (0): increment the pointer, load the next byte and continue RDATA.
    - NACK (1): go to IGNORE until STOP/START.
- Pointer rules:
  - Increment wraps from NUM_REGS-1 to 0.
  - An out-of-range pointer stays out of range (no increment).
  - Reads at an out-of-range pointer return 8'hFF.
  - The pointer persists across transactions, so a read without a pointer byte continues from the last pointer.
- Write timing: registers update on the clk after the 8th SCL rise of WDATA; reg_q reflects the new value one clk after wr_strobe.

Test Plan:
- Write burst: START, 0x54, 0x01, 0xA5, 0x5A, STOP -> 4 ACKs seen; reg1 = A5, reg2 = 5A; two wr_strobe pulses with wr_idx = 1 then 2; busy returns to 0 after STOP.
- Combined read: START, 0x54, 0x01, Sr, 0x55, read 2 bytes (master ACK then NACK), STOP -> returns A5, 5A; SDA released after NACK.
- Address mismatch: START, 0x60, 0x01, 0xFF, STOP -> no ACK (SDA high at every 9th bit), registers unchanged, no wr_strobe.
- Wrap: write pointer 0x03 followed by data 11, 22, 33 -> reg3 = 11, reg0 = 22, reg1 = 33.
- Out-of-range: NUM_REGS = 4, write pointer 0x07 followed by data 0x99, then read 1 byte -> data byte still ACKed, no wr_strobe, read returns FF.
- Reset mid-byte: assert rst_n = 0 during the 4th bit of WDATA -> sda_o = 1 immediately, all registers = REG_RESET; a following write transaction completes normally.
